// File: rtl/jt51_sched_pkg.sv
// Shared constants, types and decode helpers for the JT51 write scheduler.
package jt51_sched_pkg;

   localparam logic [7:0] A_KEYON   = 8'h08;
   localparam logic [7:0] A_RL      = 8'h20;
   localparam logic [7:0] A_KC      = 8'h28;
   localparam logic [7:0] A_KF      = 8'h30;
   localparam logic [7:0] A_PMS     = 8'h38;
   localparam logic [7:0] A_DT1     = 8'h40;
   localparam logic [7:0] A_TL      = 8'h60;
   localparam logic [7:0] A_KS      = 8'h80;
   localparam logic [7:0] A_AMSEN   = 8'hA0;
   localparam logic [7:0] A_DT2     = 8'hC0;
   localparam logic [7:0] A_D1L     = 8'hE0;
   localparam logic [7:0] A_OVF_CLR = 8'h1B;

   localparam int unsigned UP_N     = 11;
   localparam int unsigned UP_RL    = 0;
   localparam int unsigned UP_KC    = 1;
   localparam int unsigned UP_KF    = 2;
   localparam int unsigned UP_PMS   = 3;
   localparam int unsigned UP_DT1   = 4;
   localparam int unsigned UP_TL    = 5;
   localparam int unsigned UP_KS    = 6;
   localparam int unsigned UP_AMSEN = 7;
   localparam int unsigned UP_DT2   = 8;
   localparam int unsigned UP_D1L   = 9;
   localparam int unsigned UP_KEYON = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_HOLD = 2'd2
   } sched_st_e;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_entry_t;

   // Registers below 0x20 other than key-on never touch the bank handshake.
   function automatic logic is_glob(input logic [7:0] a);
      return (a[7:5] == 3'b000) && (a != A_KEYON);
   endfunction

   function automatic logic [UP_N-1:0] up_decode(input logic [7:0] a);
      logic [UP_N-1:0] v;
      v = '0;
      if (a == A_KEYON) begin
         v[UP_KEYON] = 1'b1;
      end else if (a[7:5] == 3'b001) begin
         case (a & 8'hF8)
            A_RL:    v[UP_RL]  = 1'b1;
            A_KC:    v[UP_KC]  = 1'b1;
            A_KF:    v[UP_KF]  = 1'b1;
            A_PMS:   v[UP_PMS] = 1'b1;
            default: v = '0;
         endcase
      end else begin
         case (a & 8'hE0)
            A_DT1:   v[UP_DT1]   = 1'b1;
            A_TL:    v[UP_TL]    = 1'b1;
            A_KS:    v[UP_KS]    = 1'b1;
            A_AMSEN: v[UP_AMSEN] = 1'b1;
            A_DT2:   v[UP_DT2]   = 1'b1;
            A_D1L:   v[UP_D1L]   = 1'b1;
            default: v = '0;
         endcase
      end
      return v;
   endfunction

endpackage

// File: rtl/jt51_wr_sched_fifo.sv
// Synchronous FIFO holding pending {addr,data} writes; pushes on full are dropped.
module jt51_wr_fifo #(
   parameter int unsigned AW = 2,
   parameter int unsigned W  = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign dout  = mem_q[rd_q];

   always_comb begin
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      wr_d    = do_push ? wr_q + AW'(1) : wr_q;
      rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
      cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/jt51_wr_sched.sv
// CPU-to-register-bank write scheduler: FIFO plus IDLE/ARM/HOLD strobe sequencer.
// Optional sticky overflow flag enabled by defining JT51_WR_SCHED_OVF_EN.
module jt51_wr_sched #(
   parameter int unsigned FIFO_AW = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_wr,
   input  logic       cpu_a0,
   input  logic [7:0] cpu_din,
   output logic       cpu_full,
   input  logic       bank_busy,
   output logic [7:0] d_out,
   output logic [1:0] op,
   output logic [2:0] ch,
   output logic       up_rl,
   output logic       up_kc,
   output logic       up_kf,
   output logic       up_pms,
   output logic       up_dt1,
   output logic       up_tl,
   output logic       up_ks,
   output logic       up_amsen,
   output logic       up_dt2,
   output logic       up_d1l,
   output logic       up_keyon,
   output logic       glob_we,
   output logic [7:0] glob_addr,
   output logic       sched_ovf
);
   import jt51_sched_pkg::*;

   localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
   localparam logic [1:0] S_ARM  = 2'(ST_ARM);
   localparam logic [1:0] S_HOLD = 2'(ST_HOLD);

   logic [1:0]      state_q, state_d;
   logic [7:0]      addr_q, addr_d;
   logic [UP_N-1:0] up_q, up_d;
   logic [1:0]      op_q, op_d;
   logic [2:0]      ch_q, ch_d;
   logic [7:0]      dout_q, dout_d;
   logic            glob_we_q, glob_we_d;
   logic [7:0]      glob_addr_q, glob_addr_d;

   logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [FIFO_AW:0] fifo_cnt;
   wr_entry_t       push_ent, head;

   jt51_wr_fifo #(.AW(FIFO_AW), .W(16)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (push_ent),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );

   always_comb begin
      addr_d = addr_q;
      if (cpu_wr & ~cpu_a0) addr_d = cpu_din;
      fifo_push     = cpu_wr & cpu_a0 & ~fifo_full;
      push_ent.addr = addr_q;
      push_ent.data = cpu_din;
   end

   // Sequencer: strobe stays up from pop until the bank finishes one busy round.
   always_comb begin
      state_d     = state_q;
      up_d        = up_q;
      op_d        = op_q;
      ch_d        = ch_q;
      dout_d      = dout_q;
      glob_we_d   = 1'b0;
      glob_addr_d = glob_addr_q;
      fifo_pop    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               dout_d   = head.data;
               if (is_glob(head.addr)) begin
                  glob_we_d   = 1'b1;
                  glob_addr_d = head.addr;
               end else begin
                  up_d    = up_decode(head.addr);
                  ch_d    = (head.addr == A_KEYON) ? 3'd0 : head.addr[2:0];
                  // Address order M1,C1,M2,C2 becomes pipeline order by swapping a[4:3].
                  op_d    = (head.addr[7:6] != 2'b00) ? {head.addr[3], head.addr[4]} : 2'd0;
                  state_d = S_ARM;
               end
            end
         end
         S_ARM: begin
            if (bank_busy) state_d = S_HOLD;
         end
         S_HOLD: begin
            if (!bank_busy) begin
               up_d    = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            up_d    = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         up_q        <= '0;
         op_q        <= '0;
         ch_q        <= '0;
         dout_q      <= '0;
         glob_we_q   <= 1'b0;
         glob_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         up_q        <= up_d;
         op_q        <= op_d;
         ch_q        <= ch_d;
         dout_q      <= dout_d;
         glob_we_q   <= glob_we_d;
         glob_addr_q <= glob_addr_d;
      end
   end

`ifdef JT51_WR_SCHED_OVF_EN
   logic ovf_q, ovf_d;

   // Sticky: set by a write dropped on full, cleared by address write 0x1B.
   always_comb begin
      ovf_d = ovf_q;
      if (cpu_wr & cpu_a0 & fifo_full) ovf_d = 1'b1;
      else if (cpu_wr & ~cpu_a0 & (cpu_din == A_OVF_CLR)) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign sched_ovf = ovf_q;
`else
   assign sched_ovf = 1'b0;
`endif

   assign cpu_full  = (fifo_cnt == (FIFO_AW+1)'(1 << FIFO_AW));
   assign d_out     = dout_q;
   assign op        = op_q;
   assign ch        = ch_q;
   assign glob_we   = glob_we_q;
   assign glob_addr = glob_addr_q;
   assign up_rl     = up_q[UP_RL];
   assign up_kc     = up_q[UP_KC];
   assign up_kf     = up_q[UP_KF];
   assign up_pms    = up_q[UP_PMS];
   assign up_dt1    = up_q[UP_DT1];
   assign up_tl     = up_q[UP_TL];
   assign up_ks     = up_q[UP_KS];
   assign up_amsen  = up_q[UP_AMSEN];
   assign up_dt2    = up_q[UP_DT2];
   assign up_d1l    = up_q[UP_D1L];
   assign up_keyon  = up_q[UP_KEYON];

endmodule

// File: tb/tb_jt51_wr_sched.sv
// Self-checking bench for jt51_wr_sched: vector table, scoreboard queue and a 32-slot bank model.
module tb_jt51_wr_sched;

   localparam logic [10:0] E_NONE  = 11'h000;
   localparam logic [10:0] E_RL    = 11'h001;
   localparam logic [10:0] E_KC    = 11'h002;
   localparam logic [10:0] E_KF    = 11'h004;
   localparam logic [10:0] E_PMS   = 11'h008;
   localparam logic [10:0] E_DT1   = 11'h010;
   localparam logic [10:0] E_TL    = 11'h020;
   localparam logic [10:0] E_KS    = 11'h040;
   localparam logic [10:0] E_AMSEN = 11'h080;
   localparam logic [10:0] E_DT2   = 11'h100;
   localparam logic [10:0] E_D1L   = 11'h200;
   localparam logic [10:0] E_KEYON = 11'h400;

`ifdef JT51_WR_SCHED_OVF_EN
   localparam logic EXP_OVF = 1'b1;
`else
   localparam logic EXP_OVF = 1'b0;
`endif

   typedef struct packed {
      logic [7:0]  addr;
      logic [7:0]  data;
      logic        glob;
      logic [10:0] up;
      logic [1:0]  op;
      logic [2:0]  ch;
   } vec_t;

   typedef struct packed {
      logic        glob;
      logic [10:0] up;
      logic [1:0]  op;
      logic [2:0]  ch;
      logic [7:0]  data;
      logic [7:0]  gaddr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, cpu_wr, cpu_a0;
   logic [7:0]  cpu_din;
   logic        cpu_full, glob_we, sched_ovf;
   logic [7:0]  d_out, glob_addr;
   logic [1:0]  op;
   logic [2:0]  ch;
   logic        up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l, up_keyon;
   logic [10:0] up_vec;
   logic        bank_busy = 1'b0;
   logic [4:0]  slot = 5'd0;
   logic [7:0]  kc_reg [8];

   int checks = 0;
   int errors = 0;
   exp_t sb_q[$];
   vec_t vecs[15];

   jt51_wr_sched #(.FIFO_AW(2)) dut (
      .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_a0(cpu_a0), .cpu_din(cpu_din),
      .cpu_full(cpu_full), .bank_busy(bank_busy), .d_out(d_out), .op(op), .ch(ch),
      .up_rl(up_rl), .up_kc(up_kc), .up_kf(up_kf), .up_pms(up_pms), .up_dt1(up_dt1),
      .up_tl(up_tl), .up_ks(up_ks), .up_amsen(up_amsen), .up_dt2(up_dt2), .up_d1l(up_d1l),
      .up_keyon(up_keyon), .glob_we(glob_we), .glob_addr(glob_addr), .sched_ovf(sched_ovf)
   );

   assign up_vec = {up_keyon, up_d1l, up_dt2, up_amsen, up_ks, up_tl, up_dt1, up_pms, up_kf, up_kc, up_rl};

   always #5 clk = ~clk;

   // Bank model: busy toggles only at slot 31; a strobe seen there starts a 32-cycle round.
   always @(posedge clk) begin
      slot <= slot + 5'd1;
      if (slot == 5'd31) begin
         if (bank_busy) bank_busy <= 1'b0;
         else if (up_vec != 11'h000) begin
            bank_busy <= 1'b1;
            if (up_kc) kc_reg[ch] <= d_out;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on each glob pulse / strobe rise, times each strobe.
   int          neg_cnt = 0, start_n = 0, busy_n = -1, rounds = 0;
   int          last_fall = -1000, glob_gap = -1, ev_cnt = 0;
   int          stab_viol = 0, onehot_viol = 0;
   logic [10:0] prev_up = 11'h000;
   logic        prev_busy = 1'b0;
   logic [1:0]  hold_op;
   logic [2:0]  hold_ch;
   logic [7:0]  hold_d;
   exp_t        mon_e;

   always @(negedge clk) begin
      neg_cnt++;
      if (rst) begin
         prev_up   = 11'h000;
         prev_busy = bank_busy;
      end else begin
         if ($countones(up_vec) > 1) onehot_viol++;
         if (glob_we) begin
            ev_cnt++;
            glob_gap = neg_cnt - last_fall;
            if (sb_q.size() == 0) check("glob_unexpected", 32'd1, 32'd0);
            else begin
               mon_e = sb_q.pop_front();
               check("glob_kind", 32'd1, 32'(mon_e.glob));
               check("glob_addr", 32'(glob_addr), 32'(mon_e.gaddr));
               check("glob_data", 32'(d_out), 32'(mon_e.data));
            end
         end
         if (up_vec != 11'h000 && prev_up == 11'h000) begin
            ev_cnt++;
            start_n = neg_cnt;
            busy_n  = -1;
            rounds  = 0;
            hold_op = op;
            hold_ch = ch;
            hold_d  = d_out;
            if (sb_q.size() == 0) check("strobe_unexpected", 32'd1, 32'd0);
            else begin
               mon_e = sb_q.pop_front();
               check("strobe_up", 32'(up_vec), 32'(mon_e.up));
               check("strobe_op", 32'(op), 32'(mon_e.op));
               check("strobe_ch", 32'(ch), 32'(mon_e.ch));
               check("strobe_data", 32'(d_out), 32'(mon_e.data));
            end
         end else if (up_vec != 11'h000) begin
            if (up_vec != prev_up || op != hold_op || ch != hold_ch || d_out != hold_d) stab_viol++;
         end
         if (up_vec != 11'h000 && bank_busy && !prev_busy) begin
            rounds++;
            if (busy_n < 0) busy_n = neg_cnt;
         end
         if (up_vec == 11'h000 && prev_up != 11'h000) begin
            last_fall = neg_cnt;
            check("strobe_rounds", 32'(rounds), 32'd1);
            check("strobe_width", 32'(neg_cnt - start_n), 32'(busy_n - start_n + 33));
            check("strobe_latency_le65", 32'(neg_cnt - start_n <= 65), 32'd1);
         end
         prev_up   = up_vec;
         prev_busy = bank_busy;
      end
   end

   task automatic cpu_addr(input logic [7:0] a);
      @(negedge clk);
      cpu_wr = 1'b1; cpu_a0 = 1'b0; cpu_din = a;
      @(negedge clk);
      cpu_wr = 1'b0;
   endtask

   task automatic cpu_data(input logic [7:0] d);
      @(negedge clk);
      cpu_wr = 1'b1; cpu_a0 = 1'b1; cpu_din = d;
      @(negedge clk);
      cpu_wr = 1'b0;
   endtask

   task automatic push_exp(input vec_t v);
      exp_t e;
      e.glob = v.glob; e.up = v.up; e.op = v.op; e.ch = v.ch;
      e.data = v.data; e.gaddr = v.addr;
      sb_q.push_back(e);
   endtask

   task automatic cpu_write(input vec_t v);
      cpu_addr(v.addr);
      push_exp(v);
      cpu_data(v.data);
   endtask

   task automatic wait_drain(input string name, input int max);
      int n = 0;
      while ((sb_q.size() != 0 || up_vec != 11'h000) && n < max) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check({name, "_drain"}, 32'(sb_q.size() == 0 && up_vec == 11'h000), 32'd1);
   endtask

   task automatic wait_strobe(input string name, input logic need_busy);
      int n = 0;
      while (!(up_vec != 11'h000 && (!need_busy || bank_busy)) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_strobe_seen"}, 32'(n < 100), 32'd1);
   endtask

   initial begin
      int ev0;
      rst = 1'b1; cpu_wr = 1'b0; cpu_a0 = 1'b0; cpu_din = 8'h00;

      vecs[0]  = '{8'h28, 8'h4A, 1'b0, E_KC,    2'd0, 3'd0};
      vecs[1]  = '{8'h48, 8'h15, 1'b0, E_DT1,   2'b10, 3'd0};
      vecs[2]  = '{8'h20, 8'hC7, 1'b0, E_RL,    2'd0, 3'd0};
      vecs[3]  = '{8'h3D, 8'h11, 1'b0, E_PMS,   2'd0, 3'd5};
      vecs[4]  = '{8'h33, 8'h22, 1'b0, E_KF,    2'd0, 3'd3};
      vecs[5]  = '{8'h57, 8'h33, 1'b0, E_DT1,   2'b01, 3'd7};
      vecs[6]  = '{8'h7A, 8'h44, 1'b0, E_TL,    2'b11, 3'd2};
      vecs[7]  = '{8'h8C, 8'h55, 1'b0, E_KS,    2'b10, 3'd4};
      vecs[8]  = '{8'hA1, 8'h66, 1'b0, E_AMSEN, 2'b00, 3'd1};
      vecs[9]  = '{8'hD9, 8'h77, 1'b0, E_DT2,   2'b11, 3'd1};
      vecs[10] = '{8'hF6, 8'h88, 1'b0, E_D1L,   2'b01, 3'd6};
      vecs[11] = '{8'h08, 8'h5A, 1'b0, E_KEYON, 2'd0, 3'd0};
      vecs[12] = '{8'h0F, 8'h99, 1'b1, E_NONE,  2'd0, 3'd0};
      vecs[13] = '{8'h1F, 8'h01, 1'b1, E_NONE,  2'd0, 3'd0};
      vecs[14] = '{8'h00, 8'h02, 1'b1, E_NONE,  2'd0, 3'd0};

      repeat (3) @(negedge clk);
      check("reset_strobes_glob", 32'({up_vec, glob_we, cpu_full, sched_ovf}), 32'd0);
      check("reset_data_fields", 32'({d_out, op, ch, glob_addr}), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         cpu_write(vecs[i]);
         wait_drain("vec", 200);
         if (i == 0) check("kc_reg_ch0", 32'(kc_reg[0]), 32'h4A);
      end

      // Fill the FIFO while a strobe is armed; the fifth write must be dropped.
      cpu_write('{8'h28, 8'h01, 1'b0, E_KC, 2'd0, 3'd0});
      wait_strobe("full", 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 3) check("full_after_3", 32'(cpu_full), 32'd0);
         if (i == 4) check("full_after_4", 32'(cpu_full), 32'd1);
         cpu_wr = 1'b1; cpu_a0 = 1'b1; cpu_din = 8'h10 + 8'(i);
         if (i < 4) push_exp('{8'h28, 8'h10 + 8'(i), 1'b0, E_KC, 2'd0, 3'd0});
      end
      @(negedge clk);
      cpu_wr = 1'b0;
      check("full_after_5", 32'(cpu_full), 32'd1);
      check("ovf_after_drop", 32'(sched_ovf), 32'(EXP_OVF));
      wait_drain("full", 600);
      check("ovf_sticky", 32'(sched_ovf), 32'(EXP_OVF));
      cpu_addr(8'h28);
      check("ovf_other_addr", 32'(sched_ovf), 32'(EXP_OVF));
      cpu_addr(8'h1B);
      check("ovf_clear_1b", 32'(sched_ovf), 32'd0);

      // Global write queued during HOLD pulses right after the strobe drops.
      cpu_write('{8'h28, 8'hA5, 1'b0, E_KC, 2'd0, 3'd0});
      wait_strobe("hold", 1'b1);
      cpu_write('{8'h14, 8'h30, 1'b1, E_NONE, 2'd0, 3'd0});
      wait_drain("hold", 200);
      check("glob_after_hold_gap", 32'(glob_gap), 32'd1);

      // Reset in HOLD with a second entry pending.
      cpu_write('{8'h28, 8'h66, 1'b0, E_KC, 2'd0, 3'd0});
      push_exp('{8'h28, 8'h67, 1'b0, E_KC, 2'd0, 3'd0});
      cpu_data(8'h67);
      wait_strobe("rst", 1'b1);
      @(negedge clk);
      rst = 1'b1;
      sb_q.delete();
      @(negedge clk);
      check("rst_mid_up", 32'(up_vec), 32'd0);
      check("rst_mid_full", 32'(cpu_full), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 100 && bank_busy; n++) @(negedge clk);
      ev0 = ev_cnt;
      repeat (40) @(negedge clk);
      check("rst_fifo_empty", 32'(ev_cnt - ev0), 32'd0);
      cpu_data(8'h55);
      push_exp('{8'h00, 8'h55, 1'b1, E_NONE, 2'd0, 3'd0});
      wait_drain("rst_latch", 50);

      // Key-on immediately followed by TL.
      cpu_write('{8'h08, 8'h78, 1'b0, E_KEYON, 2'd0, 3'd0});
      cpu_write('{8'h60, 8'h7F, 1'b0, E_TL, 2'd0, 3'd0});
      wait_drain("keyon_tl", 300);

      check("onehot_violations", 32'(onehot_viol), 32'd0);
      check("stability_violations", 32'(stab_viol), 32'd0);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
